// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/exec/mem sequencer owning pc and ir and arbitrating the single memory port.
// Optional memory-wait timeout to FAULT is enabled with `define SEQ_TIMEOUT_EN.
//
// state  | meaning
// FETCH  | mem_req at pc, wait for mem_ready, latch ir, pc+1
// DECODE | one settle cycle for decoder/register file, no strobes
// EXEC   | dispatch on op_class: ALU commit, branch/jump pc update, or go to MEM
// MEM    | data access at dp_addr (write for STORE), LOAD commits on mem_ready
// HALT   | stopped, all strobes low, left only through CLR
// FAULT  | memory wait timed out, all strobes low, left only through CLR
module cpu_sequencer #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [17:0] mem_dout,
    input  logic        mem_ready,
    input  logic [2:0]  op_class,
    input  logic [4:0]  flags,
    input  logic [15:0] dp_addr,
    output logic [17:0] ir,
    output logic [15:0] pc,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        flags_we,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        HALT   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_STORE  = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_JUMP   = 3'd4;
    localparam logic [2:0] OP_HALT   = 3'd5;

    state_t      state, state_nx;
    logic [15:0] pc_r, pc_nx;
    logic [17:0] ir_r, ir_nx;
    logic        store_r, store_nx;
    logic        taken;
    logic        mem_wait;
    logic        wait_expired;

    // flag F is not a branch condition source
    logic unused_bits;
    assign unused_bits = &{1'b0, flags[2]};

    assign ir       = ir_r;
    assign pc       = pc_r;
    assign halted   = (state == HALT) || (state == FAULT);
    assign mem_wait = ((state == FETCH) || (state == MEM)) && !mem_ready;

    always_comb begin
        case (ir_r[11:8])
            4'd0:    taken = flags[1];
            4'd1:    taken = !flags[1];
            4'd2:    taken = flags[4];
            4'd3:    taken = !flags[4];
            4'd4:    taken = flags[3];
            4'd5:    taken = !flags[3];
            4'd6:    taken = flags[0];
            4'd7:    taken = !flags[0];
            4'd14:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

`ifdef SEQ_TIMEOUT_EN
    logic [7:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (CLR || !mem_wait) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign wait_expired = mem_wait && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign fault        = (state == FAULT);
`else
    logic unused_cfg;
    assign unused_cfg   = &{1'b0, TIMEOUT_CYCLES[0]};
    assign wait_expired = 1'b0;
    assign fault        = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pc_nx    = pc_r;
        ir_nx    = ir_r;
        store_nx = store_r;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        flags_we = 1'b0;
        mem_addr = pc_r;

        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_nx    = mem_dout;
                    pc_nx    = pc_r + 16'd1;
                    state_nx = DECODE;
                end
            end
            DECODE: state_nx = EXEC;
            EXEC: begin
                state_nx = FETCH;
                case (op_class)
                    OP_ALU: begin
                        reg_we   = 1'b1;
                        flags_we = 1'b1;
                    end
                    OP_LOAD: begin
                        store_nx = 1'b0;
                        state_nx = MEM;
                    end
                    OP_STORE: begin
                        store_nx = 1'b1;
                        state_nx = MEM;
                    end
                    OP_BRANCH: begin
                        // pc already points past the branch, displacement is relative to that
                        if (taken) pc_nx = pc_r + {{8{ir_r[7]}}, ir_r[7:0]};
                    end
                    OP_JUMP: pc_nx = dp_addr;
                    OP_HALT: state_nx = HALT;
                    default: state_nx = FETCH;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = store_r;
                mem_addr = dp_addr;
                if (mem_ready) begin
                    reg_we   = !store_r;
                    state_nx = FETCH;
                end
            end
            default: state_nx = state;
        endcase

        if (wait_expired) state_nx = FAULT;

        if (CLR) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            reg_we   = 1'b0;
            flags_we = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state   <= FETCH;
            pc_r    <= RESET_PC;
            ir_r    <= 18'd0;
            store_r <= 1'b0;
        end else begin
            state   <= state_nx;
            pc_r    <= pc_nx;
            ir_r    <= ir_nx;
            store_r <= store_nx;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: per-cycle strobe/address checks against an
// instruction-level reference model, with randomized wait states and instruction mixes.
module tb_cpu_sequencer;

    localparam logic [15:0] RESET_PC = 16'h0000;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [17:0] mem_dout;
    logic        mem_ready;
    logic [2:0]  op_class;
    logic [4:0]  flags;
    logic [15:0] dp_addr;
    logic [17:0] ir;
    logic [15:0] pc;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic        flags_we;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] pc_m;

    cpu_sequencer #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(255)) dut (
        .CLK(CLK), .CLR(CLR), .mem_dout(mem_dout), .mem_ready(mem_ready),
        .op_class(op_class), .flags(flags), .dp_addr(dp_addr), .ir(ir), .pc(pc),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .flags_we(flags_we), .halted(halted), .fault(fault)
    );

    always #5 CLK = ~CLK;

    // Conditions come in complementary pairs over Z, C, L, N; code 14 is always.
    function automatic bit cond_taken(input logic [3:0] c, input logic [4:0] f);
        int sel[4] = '{1, 4, 3, 0};
        if (c == 4'd14) return 1'b1;
        if (c >= 4'd8) return 1'b0;
        return bit'(f[sel[c[2:1]]] ^ c[0]);
    endfunction

    task automatic do_reset();
        CLR = 1'b1;
        mem_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b0;
        pc_m = RESET_PC;
    endtask

    // Runs one instruction with wf fetch wait cycles and wm data wait cycles.
    task automatic run_instr(input logic [2:0] op, input logic [17:0] word, input int wf,
                             input int wm, input logic [15:0] dp, input logic [4:0] flg,
                             input string tag);
        logic [15:0] pc_f, pc_n;
        logic [19:0] exp_v, got_v;
        bit is_load, is_store, is_alu, is_mem;
        int n, j, d;
        is_load  = (op == 3'd1);
        is_store = (op == 3'd2);
        is_alu   = (op == 3'd0);
        is_mem   = is_load || is_store;
        pc_f = pc_m + 16'd1;
        pc_n = pc_f;
        if (op == 3'd3 && cond_taken(word[11:8], flg)) begin
            d = word[7] ? int'(word[7:0]) - 256 : int'(word[7:0]);
            pc_n = 16'(int'(pc_f) + d);
        end
        if (op == 3'd4) pc_n = dp;
        n = 3 + wf + (is_mem ? wm + 1 : 0);
        op_class = op;
        flags    = flg;
        dp_addr  = dp;
        for (int k = 0; k < n; k++) begin
            j = k - (wf + 3);
            if (k <= wf) begin
                mem_ready = (k == wf);
                mem_dout  = word;
                exp_v = {4'b1000, pc_m};
            end else if (k == wf + 1) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_dout  = 18'($urandom);
                exp_v = {4'b0000, pc_f};
            end else if (k == wf + 2) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_dout  = 18'($urandom);
                exp_v = {2'b00, is_alu, is_alu, pc_f};
            end else begin
                mem_ready = (j == wm);
                mem_dout  = 18'($urandom);
                exp_v = {1'b1, is_store, is_load && (j == wm), 1'b0, dp};
            end
            #1;
            got_v = {mem_req, mem_we, reg_we, flags_we, mem_addr};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d {req,we,reg_we,flags_we,addr}: got %h expected %h",
                         tag, k, got_v, exp_v);
            end
            if (k == wf + 1) begin
                n_checks++;
                if (ir !== word) begin
                    n_fail++;
                    $display("FAIL %s ir: got %h expected %h", tag, ir, word);
                end
            end
            @(negedge CLK);
        end
        pc_m = pc_n;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (op == 3'd5) begin
            if ({halted, mem_req} !== 2'b10) begin
                n_fail++;
                $display("FAIL %s halt entry {halted,req}: got %b expected 10", tag, {halted, mem_req});
            end
        end else if ({pc, mem_req, mem_addr, halted} !== {pc_m, 1'b1, pc_m, 1'b0}) begin
            n_fail++;
            $display("FAIL %s next fetch {pc,req,addr,halted}: got %h %b %h %b expected %h 1 %h 0",
                     tag, pc, mem_req, mem_addr, halted, pc_m, pc_m);
        end
    endtask

    task automatic test_reset();
        CLR = 1'b1;
        mem_ready = 1'b1;
        op_class = 3'd0;
        flags = 5'h1F;
        dp_addr = 16'hBEEF;
        mem_dout = 18'h3FFFF;
        @(negedge CLK);
        #1;
        n_checks++;
        if ({mem_req, mem_we, reg_we, flags_we, halted, fault} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset strobes: got %b expected 000000",
                     {mem_req, mem_we, reg_we, flags_we, halted, fault});
        end
        n_checks++;
        if ({pc, ir} !== {RESET_PC, 18'd0}) begin
            n_fail++;
            $display("FAIL reset pc/ir: got %h/%h expected %h/00000", pc, ir, RESET_PC);
        end
        CLR = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_addr} !== {1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL reset release fetch: got req=%b addr=%h expected req=1 addr=%h",
                     mem_req, mem_addr, RESET_PC);
        end
        @(negedge CLK);
        pc_m = RESET_PC;
    endtask

    task automatic test_alu();
        run_instr(3'd0, 18'($urandom), 0, 0, 16'($urandom), 5'($urandom), "alu_zero_wait");
        n_checks++;
        if (pc !== 16'h0001) begin
            n_fail++;
            $display("FAIL alu pc: got %h expected 0001", pc);
        end
    endtask

    task automatic test_load_wait();
        run_instr(3'd1, 18'($urandom), 0, 2, 16'h0040, 5'($urandom), "load_wait2");
    endtask

    task automatic test_branch();
        run_instr(3'd4, 18'($urandom), 0, 0, 16'h0010, 5'd0, "jump_to_10");
        run_instr(3'd3, 18'h000FE, 0, 0, 16'($urandom), 5'b00010, "branch_eq_taken");
        n_checks++;
        if (pc !== 16'h000F) begin
            n_fail++;
            $display("FAIL branch taken pc: got %h expected 000F", pc);
        end
        run_instr(3'd4, 18'($urandom), 1, 0, 16'h0010, 5'd0, "jump_to_10b");
        run_instr(3'd3, 18'h000FE, 0, 0, 16'($urandom), 5'b11101, "branch_eq_not_taken");
        n_checks++;
        if (pc !== 16'h0011) begin
            n_fail++;
            $display("FAIL branch not taken pc: got %h expected 0011", pc);
        end
    endtask

    task automatic test_wrap_jump();
        run_instr(3'd4, 18'($urandom), 0, 0, 16'hFFFF, 5'd0, "jump_to_ffff");
        run_instr(3'd6, 18'($urandom), 2, 0, 16'($urandom), 5'd0, "nop_wrap");
        n_checks++;
        if (pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL pc wrap: got %h expected 0000", pc);
        end
        run_instr(3'd4, 18'($urandom), 0, 0, 16'h1234, 5'd0, "jump_1234");
    endtask

    task automatic test_random();
        logic [2:0] ops[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
        for (int i = 0; i < 40; i++) begin
            run_instr(ops[$urandom_range(0, 6)], 18'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), 16'($urandom), 5'($urandom), "random");
        end
    endtask

    task automatic test_halt();
        run_instr(3'd5, 18'($urandom), 0, 0, 16'($urandom), 5'($urandom), "halt");
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            op_class  = 3'($urandom);
            #1;
            n_checks++;
            if ({mem_req, mem_we, reg_we, flags_we, halted} !== 5'b00001) begin
                n_fail++;
                $display("FAIL halted cycle %0d {req,we,reg_we,flags_we,halted}: got %b expected 00001",
                         i, {mem_req, mem_we, reg_we, flags_we, halted});
            end
            @(negedge CLK);
        end
        do_reset();
        #1;
        n_checks++;
        if ({halted, mem_req, pc} !== {1'b0, 1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL halt exit via CLR: got halted=%b req=%b pc=%h", halted, mem_req, pc);
        end
    endtask

    task automatic test_clr_mid_store();
        run_instr(3'd4, 18'($urandom), 0, 0, 16'h0200, 5'd0, "jump_200");
        op_class = 3'd2;
        dp_addr  = 16'h0300;
        mem_dout = 18'($urandom);
        mem_ready = 1'b1;
        @(negedge CLK);
        mem_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        n_checks++;
        if ({mem_req, mem_we, mem_addr} !== {2'b11, 16'h0300}) begin
            n_fail++;
            $display("FAIL store access: got req=%b we=%b addr=%h expected 1 1 0300",
                     mem_req, mem_we, mem_addr);
        end
        CLR = 1'b1;
        #1;
        n_checks++;
        if ({mem_req, mem_we, reg_we, flags_we} !== 4'b0000) begin
            n_fail++;
            $display("FAIL CLR mid store strobes: got %b expected 0000",
                     {mem_req, mem_we, reg_we, flags_we});
        end
        @(negedge CLK);
        CLR = 1'b0;
        #1;
        n_checks++;
        if ({pc, ir, mem_req, mem_addr} !== {RESET_PC, 18'd0, 1'b1, RESET_PC}) begin
            n_fail++;
            $display("FAIL after CLR mid store: got pc=%h ir=%h req=%b addr=%h", pc, ir, mem_req, mem_addr);
        end
        pc_m = RESET_PC;
        @(negedge CLK);
    endtask

    task automatic test_timeout();
        bit exp_f;
        do_reset();
        op_class = 3'($urandom);
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLK);
            #1;
`ifdef SEQ_TIMEOUT_EN
            exp_f = (k >= 255);
`else
            exp_f = 1'b0;
`endif
            n_checks++;
            if ({fault, halted, mem_req, mem_we} !== {exp_f, exp_f, !exp_f, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout wait %0d {fault,halted,req,we}: got %b expected %b",
                         k, {fault, halted, mem_req, mem_we}, {exp_f, exp_f, !exp_f, 1'b0});
            end
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_wrap_jump();
        test_random();
        test_halt();
        test_clr_mid_store();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit register-file/ALU datapath. Owns the program counter and the 18-bit instruction register, fetches instructions from the shared memory port, and steps each instruction through decode, execute and memory phases. It gates register-file writes, flag latching and memory strobes so the combinational datapath only commits on the correct cycle. It sits between the memory module and the decoder/datapath and arbitrates the single memory port between instruction fetch and data access.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, maximum memory wait cycles before fault (used only with SEQ_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock, all state on rising edge.
- CLR  in  1  reset; synchronous, active-high.
- mem_dout  in  18  memory read data (instruction on fetch).
- mem_ready  in  1  memory access complete this cycle.
- op_class  in  3  from decoder: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HALT, 6/7 NOP.
- flags  in  5  ALU flags {C,L,F,Z,N} (bit 4 = C, bit 0 = N).
- dp_addr  in  16  datapath A-bus (register A value): load/store address, jump target.
- ir  out  18  instruction register, drives decoder inst input.
- pc  out  16  program counter.
- mem_addr  out  16  memory address.
- mem_req  out  1  memory access strobe.
- mem_we  out  1  memory write strobe (store only).
- reg_we  out  1  register-file write enable qualifier.
- flags_we  out  1  flag register latch enable.
- halted  out  1  sequencer stopped (HALT or FAULT).
- fault  out  1  memory timeout fault.

## Operation
- States: FETCH, DECODE, EXEC, MEM, HALT, FAULT. Reset state FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: ir<=mem_dout, pc<=pc+1 (wraps FFFF->0000), go DECODE. Otherwise hold.
- DECODE: one cycle, no strobes; decoder/register outputs settle. Go EXEC.
- EXEC by op_class:
  - ALU: reg_we=1, flags_we=1 for this cycle; go FETCH.
  - LOAD/STORE: go MEM.
  - BRANCH: cond=ir[11:8]; taken -> pc<=pc+sext(ir[7:0]) (mod 2^16, pc already incremented). Go FETCH.
  - JUMP: pc<=dp_addr; go FETCH.
  - HALT: go HALT. NOP: go FETCH.
- Conditions: 0 EQ Z=1; 1 NE Z=0; 2 CS C=1; 3 CC C=0; 4 LO L=1; 5 HS L=0; 6 LT N=1; 7 GE N=0; 14 always; all others never.
- MEM: mem_req=1, mem_addr=dp_addr, mem_we=1 for STORE. On mem_ready: LOAD asserts reg_we that cycle (result mux selects memory data); go FETCH. Otherwise hold, strobes steady.
- HALT: all strobes 0, halted=1; exit only via CLR.
- mem_addr=pc in all non-MEM states.

## Timing
- Reset (CLR high at edge): pc=RESET_PC, ir=0, state=FETCH, fault=0, halted=0. While CLR high, mem_req, mem_we, reg_we, flags_we forced 0 combinationally.
- CLR mid-access: access abandoned, strobes drop same cycle, no register/PC commit.
- Strobes are Moore decodes of state (plus op_class/mem_ready for reg_we); mem_ready sampled same cycle as mem_req.
- Zero-wait latency: ALU/BRANCH/JUMP/NOP 3 cycles; LOAD/STORE 4 cycles; each wait cycle adds 1.
- flags sampled in EXEC for branch: they reflect the last flags_we commit.

## Configuration
- SEQ_TIMEOUT_EN defined: 8-bit wait counter cleared on entering FETCH/MEM, increments each cycle mem_ready=0; reaching TIMEOUT_CYCLES -> FAULT (strobes 0, fault=1, halted=1, until CLR).
- Undefined: no counter, waits indefinitely; fault tied 0, FAULT unreachable.

## Test plan
- CLR, zero-wait memory, ir word ALU at address 0 -> mem_req in FETCH, reg_we+flags_we single pulse on cycle 3, pc=0001.
- LOAD with mem_ready delayed 2 cycles, dp_addr=0x0040 -> mem_addr=0x0040 held, reg_we only on ready cycle, total 6 cycles.
- BRANCH EQ disp=0xFE at pc=0x0010, Z=1 -> pc=0x000F; Z=0 -> pc=0x0011.
- pc=0xFFFF fetch -> pc wraps to 0x0000; JUMP dp_addr=0x1234 -> next fetch address 0x1234.
- HALT -> halted=1, no strobes for 20 cycles; CLR during MEM store -> mem_we drops same cycle, pc=RESET_PC.
- SEQ_TIMEOUT_EN, mem_ready stuck 0 -> fault=1 after 255 wait cycles; without macro, still waiting, fault=0.
